// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types and constants for the data-memory responder.
//   - dmem_state_e : responder FSM state encodings (IDLE / BUSY / RESP).
//   - CntWidth     : width of the latency down-counter (LATENCY up to 15).
// `BUS_WIDTH and `ZERO_WORD normally come from the shared defines.v header; the fallbacks
// below only apply when that header has not already been seen.
// Optional feature macro used by this slice: DMEM_RESP_ERR_EN (address range check).

`ifndef BUS_WIDTH
`define BUS_WIDTH 64
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 64'h0
`endif

package dmem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

  localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port 2^DEPTH_LOG2 x `BUS_WIDTH RAM with per-bit write mask.
// Kept as its own module so the storage can be swapped for an SRAM macro.
// Ports:
//   clk   in  rising-edge clock
//   en    in  access strobe (one access per request)
//   we    in  1 = masked write, 0 = read
//   idx   in  doubleword index
//   wmask in  per-bit write enable
//   wdata in  write data
//   rdata out registered read data; updated only by a read access
// Contents are not reset.

module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [`BUS_WIDTH-1:0] wmask,
  input  logic [`BUS_WIDTH-1:0] wdata,
  output logic [`BUS_WIDTH-1:0] rdata
);

  logic [`BUS_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the data-memory path.
// Accepts one request at a time (valid/ready), waits LATENCY cycles in BUSY, performs one
// masked write or full-doubleword read of the internal array, then holds the response
// (valid/ready) until taken. req_ready is high only in IDLE, so requests never overlap.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we              1 = masked write, 0 = read
//   req_addr            byte address, bits [2:0] ignored
//   req_wmask/req_wdata per-bit write enable and lane-aligned write data
//   resp_valid/resp_ready response handshake
//   resp_rdata          read data (0 for writes and faulted requests)
//   resp_err            address fault (only with DMEM_RESP_ERR_EN, otherwise 0)
// Macro DMEM_RESP_ERR_EN: when defined, out-of-range requests are faulted instead of
// wrapping modulo the array size.

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 1,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [`BUS_WIDTH-1:0] req_addr,
  input  logic [`BUS_WIDTH-1:0] req_wmask,
  input  logic [`BUS_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [`BUS_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned IdxHi = DEPTH_LOG2 + 2;
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(LATENCY - 1);

  dmem_state_e state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic                  cap_we_q;
  logic [DEPTH_LOG2-1:0] cap_idx_q;
  logic [`BUS_WIDTH-1:0] cap_wmask_q;
  logic [`BUS_WIDTH-1:0] cap_wdata_q;
  logic                  cap_err_q;

  // resp_rd_q marks a read response; it gates the RAM output so writes, faults and reset
  // all present zero without a second data register.
  logic                  resp_rd_q;
  logic                  resp_err_q;

  logic                  accept;
  logic                  busy_done;
  logic                  arr_en;
  logic [`BUS_WIDTH-1:0] offset;
  logic                  req_fault;
  logic [`BUS_WIDTH-1:0] arr_rdata;

  assign accept    = req_valid && (state_q == StIdle);
  assign busy_done = (state_q == StBusy) && (cnt_q == '0);
  // rst gates the access so a write still pending at reset never lands.
  assign arr_en    = busy_done && !cap_err_q && !rst;
  assign offset    = req_addr - BASE_ADDR;

`ifdef DMEM_RESP_ERR_EN
  assign req_fault = (req_addr < BASE_ADDR) || (|offset[`BUS_WIDTH-1:IdxHi+1]);
  logic unused_offset;
  assign unused_offset = ^offset[2:0];
`else
  assign req_fault = 1'b0;
  logic unused_offset;
  assign unused_offset = ^{offset[`BUS_WIDTH-1:IdxHi+1], offset[2:0]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StBusy;
          cnt_d   = CntLoad;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle:  req_ready  = 1'b1;
      StResp:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Counter and response flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      resp_rd_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (busy_done) begin
        resp_rd_q  <= !cap_we_q && !cap_err_q;
        resp_err_q <= cap_err_q;
      end
    end
  end

  // Request capture; only meaningful while BUSY, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we_q    <= req_we;
      cap_idx_q   <= offset[IdxHi:3];
      cap_wmask_q <= req_wmask;
      cap_wdata_q <= req_wdata;
      cap_err_q   <= req_fault;
    end
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (cap_we_q),
    .idx  (cap_idx_q),
    .wmask(cap_wmask_q),
    .wdata(cap_wdata_q),
    .rdata(arr_rdata)
  );

  assign resp_rdata = resp_rd_q ? arr_rdata : `ZERO_WORD;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 1, 3, 4) driven one at a
// time; expected responses are queued at issue and checked by a monitor at handshake.

module tb_dmem_responder;
  import dmem_responder_pkg::*;

  typedef struct packed {
    logic [1:0]  dut;
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wmask  [3];
  logic [63:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];

  int    n_tests = 0;
  int    n_fail  = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_LOG2(12),
      .LATENCY   (lat_of(g)),
      .BASE_ADDR (64'h8000_0000)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wmask (req_wmask[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin : monitor
    resp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst && resp_valid[i] && resp_ready[i]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(i), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("resp_dut", 64'(i), 64'(e.dut));
          check("resp_rdata", resp_rdata[i], e.rdata);
          check("resp_err", 64'(resp_err[i]), 64'(e.err));
        end
      end
    end
  end

  // Full transaction; called just after a rising edge.
  task automatic xact(input int d, input logic we, input logic [63:0] addr,
                      input logic [63:0] wmask, input logic [63:0] wdata,
                      input logic [63:0] erd, input logic eerr, input int stall);
    int cycles;
    exp_q.push_back('{dut: 2'(d), rdata: erd, err: eerr});
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wmask[d] = wmask;
    req_wdata[d] = wdata;
    check("req_ready_idle", 64'(req_ready[d]), 64'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    cycles = 0;
    while (!resp_valid[d] && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("resp_latency", 64'(cycles), 64'(lat_of(d)));
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 64'(resp_valid[d]), 64'd1);
      check("stall_req_ready", 64'(req_ready[d]), 64'd0);
      check("stall_rdata", resp_rdata[d], erd);
      @(posedge clk); #1;
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    check("post_req_ready", 64'(req_ready[d]), 64'd1);
    check("post_resp_valid", 64'(resp_valid[d]), 64'd0);
  endtask

  task automatic check_reset_state(input int d);
    check("rst_req_ready", 64'(req_ready[d]), 64'd1);
    check("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
    check("rst_resp_rdata", resp_rdata[d], 64'd0);
    check("rst_resp_err", 64'(resp_err[d]), 64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 3; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_addr[i]   = '0;
      req_wmask[i]  = '0;
      req_wdata[i]  = '0;
      resp_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) check_reset_state(i);

    // LATENCY=1: full write then read back
    xact(0, 1'b1, 64'h8000_0010, '1, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 0);
    xact(0, 1'b0, 64'h8000_0010, '0, '0, 64'h1122_3344_5566_7788, 1'b0, 0);

    // Byte-lane write onto a zeroed entry, then an all-zero mask write
    xact(0, 1'b1, 64'h8000_0000, '1, 64'h0, 64'h0, 1'b0, 0);
    xact(0, 1'b1, 64'h8000_0000, 64'h0000_0000_0000_FF00, 64'h0000_0000_0000_AB00,
         64'h0, 1'b0, 0);
    xact(0, 1'b0, 64'h8000_0000, '0, '0, 64'h0000_0000_0000_AB00, 1'b0, 0);
    xact(0, 1'b1, 64'h8000_0000, 64'h0, '1, 64'h0, 1'b0, 0);
    xact(0, 1'b0, 64'h8000_0005, '0, '0, 64'h0000_0000_0000_AB00, 1'b0, 0);

    // Sparse mask over an all-ones background
    xact(0, 1'b1, 64'h8000_0008, '1, '1, 64'h0, 1'b0, 0);
    xact(0, 1'b1, 64'h8000_0008, 64'h00FF_0000_0000_00F0, 64'h1234_5678_9ABC_DEF0,
         64'h0, 1'b0, 0);
    xact(0, 1'b0, 64'h8000_0008, '0, '0, 64'hFF34_FFFF_FFFF_FFFF, 1'b0, 0);

    // Range boundaries: below base aliases the last entry unless faulted
    xact(0, 1'b1, 64'h8000_7FF8, '1, 64'hCAFE_F00D_DEAD_BEEF, 64'h0, 1'b0, 0);
`ifdef DMEM_RESP_ERR_EN
    xact(0, 1'b1, 64'h7FFF_FFF8, '1, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1, 0);
    xact(0, 1'b0, 64'h8000_7FF8, '0, '0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 0);
    xact(0, 1'b0, 64'h8000_8000, '0, '0, 64'h0, 1'b1, 0);
`else
    xact(0, 1'b1, 64'h7FFF_FFF8, '1, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 0);
    xact(0, 1'b0, 64'h8000_7FF8, '0, '0, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
    xact(0, 1'b0, 64'h8000_8000, '0, '0, 64'h0000_0000_0000_AB00, 1'b0, 0);
`endif

    // LATENCY=4 with the response stalled for 3 cycles
    xact(2, 1'b1, 64'h8000_0020, '1, 64'hDEAD_BEEF_0000_1111, 64'h0, 1'b0, 0);
    xact(2, 1'b0, 64'h8000_0020, '0, '0, 64'hDEAD_BEEF_0000_1111, 1'b0, 3);

    // LATENCY=3: write dropped by reset the cycle after accept
    xact(1, 1'b1, 64'h8000_0030, '1, 64'hAAAA_5555_AAAA_5555, 64'h0, 1'b0, 0);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 64'h8000_0030;
    req_wmask[1] = '1;
    req_wdata[1] = 64'h0F0F_0F0F_0F0F_0F0F;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state(1);
    repeat (5) @(posedge clk);
    #1;
    check("no_resp_after_rst", 64'(resp_valid[1]), 64'd0);
    xact(1, 1'b0, 64'h8000_0030, '0, '0, 64'hAAAA_5555_AAAA_5555, 1'b0, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
